yuv422_to_yuv444: RTL and testbench
===================================

// Module: yuv422_to_yuv444
// PURPOSE
//   Chroma upsampler feeding the YCbCr->RGB stage. Takes 16-bit 4:2:2 pixels {Y,C}
//   (C alternates Cb/Cr per active pixel) and emits 24-bit 4:4:4 pixels {Y,Cb,Cr}.
//   V/H/DE are delayed to stay aligned with the data. Odd-pixel chroma is replicated
//   or linearly interpolated. Output drops straight into the 24-bit iD/iV/iH/iE input
//   of the downstream converter.
// PARAMETERS
//   INTERP    1  1: odd-pixel Cb = rounded average of neighbouring Cb samples; 0: replicate
//   CB_FIRST  1  1: even pixel carries Cb, odd carries Cr; 0: swapped
//   C_DEF     8'd128  chroma used when a component has no sample yet on the line
// PORTS
//   iSclk   in   1   pixel clock, all logic on rising edge
//   iRstN   in   1   asynchronous active-low reset
//   iD      in   16  {Y[15:8], C[7:0]}, valid when iE=1
//   iV      in   1   vertical sync / frame marker
//   iH      in   1   horizontal sync
//   iE      in   1   data enable, high for every active pixel of a line
//   oD      out  24  {Y[23:16], Cb[15:8], Cr[7:0]}
//   oV      out  1   iV delayed by LAT
//   oH      out  1   iH delayed by LAT
//   oE      out  1   iE delayed by LAT
// BEHAVIOUR
//   - Reset: oD=0, oV=0, oH=0, oE=0. All pipeline regs, phase and held chroma are cleared.
//     Reset asserted mid-line discards the partial line. No output is produced until the
//     next iE rising edge.
//   - Latency LAT=3 cycles, fixed, for data and all three timing signals.
//     oV/oH/oE(t) = iV/iH/iE(t-3), unconditionally.
//   - Line: maximal run of consecutive iE=1 cycles. A DE drop ends the line.
//     Pixel index k restarts at 0 on every iE rising edge and whenever iV=1.
//   - Phase: k even carries Cb (CB_FIRST=1), k odd carries Cr. Pair m = pixels 2m, 2m+1.
//   - Even pixel 2m output: Y=Y[2m], Cb=Cb[2m], Cr=Cr[2m+1].
//     If 2m is the last pixel of the line (odd-length line): Cr = Cr[2m-1],
//     or C_DEF if m=0.
//   - Odd pixel 2m+1 output: Y=Y[2m+1], Cr=Cr[2m+1].
//     * INTERP=1 and pixel 2m+2 exists: Cb = (Cb[2m]+Cb[2m+2]+1)>>1, 9-bit sum, no overflow.
//     * Otherwise (INTERP=0, or end of line): Cb = Cb[2m].
//   - End of line is known because iE=0 on the cycle pixel 2m+2 would arrive. This is why LAT=3.
//   - When oE=0, oD=24'd0.
//   - iV=1 while iE=1 (illegal) restarts phase at k=0. No other recovery is performed.
//   - Back-to-back lines with a 1-cycle DE gap must be handled without mixing chroma
//     across lines.
// TESTING
//   1 Reset: iRstN=0 with random inputs -> oD=0, oV=oH=oE=0. First output appears
//     exactly 3 cycles after the first iE.
//   2 INTERP=1, 4-px line {Y,C}=(10,100)(20,200)(30,120)(40,220)
//     -> oD = (10,100,200) (20,110,200) (30,120,220) (40,120,220).
//   3 INTERP=0, same line -> pixel 1 = (20,100,200); others as in scenario 2.
//   4 Odd 3-px line (10,100)(20,200)(30,50) -> third output = (30,50,200).
//     1-px line (7,90) -> (7,90,128).
//   5 Two 4-px lines separated by a 1-cycle DE gap, second line C=(10,20,30,40)
//     -> second-line pixel 1 Cb = 20, with no carry-over from line 1.
//     oE pulses are exact copies of iE delayed 3 cycles.
//   6 Reset asserted at pixel 2 of a line, released mid-line -> outputs 0 during reset.
//     Remaining pixels of that line are ignored. The next line converts correctly.
//   Check: after rounding, (255+255+1)>>1 = 255 and (0+1+1)>>1 = 1.

Source files
------------

// File: rtl/yuv422_to_yuv444.sv
// ---------------------------------------------------------------------------
// yuv422_to_yuv444
//   Chroma upsampler in front of the YCbCr->RGB stage. Accepts 16-bit 4:2:2
//   pixels {Y,C} whose chroma alternates between two components on every
//   active pixel, and produces 24-bit 4:4:4 pixels {Y,Cb,Cr}. Timing signals
//   travel through the same 3-cycle pipeline so they stay aligned with data.
//
//   Parameters
//     INTERP    1: odd-pixel first component = rounded mean of its neighbours
//               0: odd-pixel first component replicated from the even pixel
//     CB_FIRST  1: even pixels carry Cb, odd pixels carry Cr; 0: swapped
//     C_DEF     chroma used when a component has no sample on the line yet
//
//   Ports
//     iSclk   in   1   pixel clock, rising edge
//     iRstN   in   1   asynchronous active-low reset
//     iD      in   16  {Y[15:8], C[7:0]}, valid when iE=1
//     iV      in   1   vertical sync / frame marker (restarts pixel phase)
//     iH      in   1   horizontal sync
//     iE      in   1   data enable, high for every active pixel of a line
//     oD      out  24  {Y[23:16], Cb[15:8], Cr[7:0]}, zero when oE=0
//     oV      out  1   iV delayed by 3 cycles
//     oH      out  1   iH delayed by 3 cycles
//     oE      out  1   iE delayed by 3 cycles
// ---------------------------------------------------------------------------
module yuv422_to_yuv444 #(
   parameter bit         INTERP   = 1'b1,
   parameter bit         CB_FIRST = 1'b1,
   parameter logic [7:0] C_DEF    = 8'd128
) (
   input  logic        iSclk,
   input  logic        iRstN,
   input  logic [15:0] iD,
   input  logic        iV,
   input  logic        iH,
   input  logic        iE,
   output logic [23:0] oD,
   output logic        oV,
   output logic        oH,
   output logic        oE
);

   localparam int unsigned CW = 8;        // chroma sample width
   localparam int unsigned YW = 8;        // luma sample width
   localparam int unsigned SW = CW + 1;   // chroma sum width for averaging
   localparam int unsigned OW = YW + 2 * CW;

   // -----------------------------------------------------------------------
   // Input qualification
   //   After reset the remainder of any line in flight is discarded: the
   //   block waits for iE to drop before it accepts pixels again.
   // -----------------------------------------------------------------------
   logic waitLine;

   logic inE;       // accepted active pixel this cycle
   logic inStart;   // accepted pixel is k=0 of a line
   logic inOdd;     // accepted pixel has odd index k

   // Stage 0: pixel sampled one cycle ago (the "next" pixel during output)
   logic          e0;
   logic          start0;
   logic          odd0;
   logic [YW-1:0] y0;
   logic [CW-1:0] c0;
   logic          v0;
   logic          h0;

   // Stage 1: pixel whose output is being formed (the "current" pixel)
   logic          e1;
   logic          start1;
   logic          odd1;
   logic [YW-1:0] y1;
   logic [CW-1:0] c1;
   logic          v1;
   logic          h1;

   // Chroma of the pixel before the current one
   logic [CW-1:0] cPrev;

   // Output formation
   logic          nextSame;   // next pixel exists on the same line
   logic          prevSame;   // previous pixel exists on the same line
   logic [CW-1:0] avgC;
   logic [CW-1:0] firstC;     // component carried by even pixels
   logic [CW-1:0] secondC;    // component carried by odd pixels
   logic [CW-1:0] cbC;
   logic [CW-1:0] crC;
   logic [OW-1:0] dC;

   assign inE     = iE & ~waitLine;
   // A line starts on a DE rising edge, and iV forces a phase restart.
   assign inStart = inE & (~e0 | iV);
   assign inOdd   = ~inStart & ~odd0;

   // Wait-for-line-gap flag: set by reset, cleared once iE is seen low
   always_ff @(posedge iSclk or negedge iRstN) begin
      if (!iRstN) begin
         waitLine <= 1'b1;
      end else begin
         waitLine <= waitLine & iE;
      end
   end

   // Two-stage sample pipeline plus previous-chroma register
   always_ff @(posedge iSclk or negedge iRstN) begin
      if (!iRstN) begin
         e0     <= 1'b0;
         start0 <= 1'b0;
         odd0   <= 1'b0;
         y0     <= '0;
         c0     <= '0;
         v0     <= 1'b0;
         h0     <= 1'b0;
         e1     <= 1'b0;
         start1 <= 1'b0;
         odd1   <= 1'b0;
         y1     <= '0;
         c1     <= '0;
         v1     <= 1'b0;
         h1     <= 1'b0;
         cPrev  <= '0;
      end else begin
         e0     <= inE;
         start0 <= inStart;
         odd0   <= inOdd;
         y0     <= iD[15:8];
         c0     <= iD[7:0];
         v0     <= iV;
         h0     <= iH;
         e1     <= e0;
         start1 <= start0;
         odd1   <= odd0;
         y1     <= y0;
         c1     <= c0;
         v1     <= v0;
         h1     <= h0;
         cPrev  <= c1;
      end
   end

   // Neighbour availability. A following pixel flagged as a line start
   // (DE gap or iV restart) belongs to another line and must not be used.
   assign nextSame = e0 & ~start0;
   assign prevSame = ~start1;

   // Rounded mean of the two neighbouring first-component samples
   assign avgC = CW'((SW'(cPrev) + SW'(c0) + SW'(1)) >> 1);

   // Chroma reconstruction for the current pixel
   always_comb begin
      firstC  = c1;
      secondC = c1;
      if (!odd1) begin
         // Even pixel: own sample is first; second comes from the pair
         // partner, or from the previous pair when the line ends here.
         firstC = c1;
         if (nextSame) begin
            secondC = c0;
         end else if (prevSame) begin
            secondC = cPrev;
         end else begin
            secondC = C_DEF;
         end
      end else begin
         // Odd pixel: own sample is second; first is taken from the even
         // partner, or interpolated towards the following even pixel.
         secondC = c1;
         if (INTERP && nextSame) begin
            firstC = avgC;
         end else begin
            firstC = cPrev;
         end
      end
   end

   always_comb begin
      cbC = firstC;
      crC = secondC;
      if (!CB_FIRST) begin
         cbC = secondC;
         crC = firstC;
      end
   end

   assign dC = {y1, cbC, crC};

   // Registered outputs; data forced to zero outside active pixels
   always_ff @(posedge iSclk or negedge iRstN) begin
      if (!iRstN) begin
         oD <= '0;
         oV <= 1'b0;
         oH <= 1'b0;
         oE <= 1'b0;
      end else begin
         oD <= e1 ? dC : '0;
         oV <= v1;
         oH <= h1;
         oE <= e1;
      end
   end

endmodule

// File: tb/tb_yuv422_to_yuv444.sv
// ---------------------------------------------------------------------------
// tb_yuv422_to_yuv444
//   Self-checking bench for yuv422_to_yuv444. Two instances (interpolating
//   and replicating) share the same stimulus. Every cycle's inputs are
//   logged; expected outputs are computed from the logged history by
//   locating each pixel's line and index and applying the chroma rules.
// ---------------------------------------------------------------------------
module tb_yuv422_to_yuv444;

   localparam int unsigned DEPTH = 4096;

   logic        iSclk;
   logic        iRstN;
   logic [15:0] iD;
   logic        iV;
   logic        iH;
   logic        iE;

   logic [23:0] oD1, oD0;
   logic        oV1, oV0, oH1, oH0, oE1, oE0;

   yuv422_to_yuv444 #(.INTERP(1'b1), .CB_FIRST(1'b1), .C_DEF(8'd128)) dutI (
      .iSclk(iSclk), .iRstN(iRstN), .iD(iD), .iV(iV), .iH(iH), .iE(iE),
      .oD(oD1), .oV(oV1), .oH(oH1), .oE(oE1)
   );

   yuv422_to_yuv444 #(.INTERP(1'b0), .CB_FIRST(1'b1), .C_DEF(8'd128)) dutR (
      .iSclk(iSclk), .iRstN(iRstN), .iD(iD), .iV(iV), .iH(iH), .iE(iE),
      .oD(oD0), .oV(oV0), .oH(oH0), .oE(oE0)
   );

   initial iSclk = 1'b0;
   always #5 iSclk = ~iSclk;

   // Input history, indexed by the clock edge that samples it
   logic [15:0] logD [DEPTH];
   bit          logE [DEPTH];
   bit          logV [DEPTH];
   bit          logH [DEPTH];
   bit          logR [DEPTH];   // 1 = reset released during this cycle
   bit          gE   [DEPTH];   // pixel accepted (not discarded after reset)
   bit          waitB[DEPTH + 1];

   int n     = 0;
   int total = 0;
   int bad   = 0;

   // Directed expectations: pixel cycle and required oD per instance
   int          constP [$];
   logic [23:0] constI [$];
   logic [23:0] constR [$];

   task automatic cmp(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, n, obs, exp);
      end
   endtask

   // Expected {oD, oV, oH, oE} for the pixel sampled at cycle p
   function automatic logic [26:0] model(input bit interp, input int p);
      int s;
      int k;
      bit nxt;
      logic [15:0] cur, prv, nx;
      logic [7:0]  y, cb, cr;
      if (p < 0) return 27'd0;
      // Any reset between sampling and output clears the pipeline
      for (int j = p; j <= p + 2; j++) if (!logR[j]) return 27'd0;
      if (!gE[p]) return {24'd0, logV[p], logH[p], 1'b0};
      s = p;
      while (s > 0 && gE[s-1] && !logV[s]) s--;
      k   = p - s;
      nxt = gE[p+1] && !logV[p+1];
      cur = logD[p];
      nx  = logD[p+1];
      prv = (p > 0) ? logD[p-1] : 16'd0;
      y   = cur[15:8];
      if (k % 2 == 0) begin
         cb = cur[7:0];
         if (nxt)        cr = nx[7:0];
         else if (k > 0) cr = prv[7:0];
         else            cr = 8'd128;
      end else begin
         cr = cur[7:0];
         if (interp && nxt) cb = 8'((int'(prv[7:0]) + int'(nx[7:0]) + 1) / 2);
         else               cb = prv[7:0];
      end
      return {y, cb, cr, logV[p], logH[p], 1'b1};
   endfunction

   task automatic checkAll();
      int p;
      logic [26:0] exI, exR;
      if (n < 1) return;
      p   = n - 3;
      exI = model(1'b1, p);
      exR = model(1'b0, p);
      cmp("oD_interp", oD1, exI[26:3]);
      cmp("oV_interp", 24'(oV1), 24'(exI[2]));
      cmp("oH_interp", 24'(oH1), 24'(exI[1]));
      cmp("oE_interp", 24'(oE1), 24'(exI[0]));
      cmp("oD_repl",   oD0, exR[26:3]);
      cmp("oV_repl",   24'(oV0), 24'(exR[2]));
      cmp("oH_repl",   24'(oH0), 24'(exR[1]));
      cmp("oE_repl",   24'(oE0), 24'(exR[0]));
      while (constP.size() > 0 && constP[0] == p) begin
         cmp("directed_interp", oD1, constI[0]);
         cmp("directed_repl",   oD0, constR[0]);
         void'(constP.pop_front());
         void'(constI.pop_front());
         void'(constR.pop_front());
      end
   endtask

   // One clock: check outputs of the previous edge, then drive and log
   task automatic step(input bit e, input bit v, input bit h,
                       input logic [15:0] d, input bit rn);
      @(negedge iSclk);
      checkAll();
      iE    = e;
      iV    = v;
      iH    = h;
      iD    = d;
      iRstN = rn;
      logE[n] = e;
      logV[n] = v;
      logH[n] = h;
      logD[n] = d;
      logR[n] = rn;
      gE[n]   = e && rn && !waitB[n];
      waitB[n+1] = !rn || (waitB[n] && e);
      n++;
   endtask

   task automatic pix(input logic [7:0] y, input logic [7:0] c);
      step(1'b1, 1'b0, 1'b0, {y, c}, 1'b1);
   endtask

   task automatic pixC(input logic [7:0] y, input logic [7:0] c,
                       input logic [23:0] expI, input logic [23:0] expR);
      constP.push_back(n);
      constI.push_back(expI);
      constR.push_back(expR);
      pix(y, c);
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
   endtask

   initial begin
      bit e, v, h, rn;
      int len;
      iRstN = 1'b0;
      iE = 1'b0; iV = 1'b0; iH = 1'b0; iD = 16'd0;
      waitB[0] = 1'b1;

      // Reset held with random inputs, then release on an idle bus
      for (int i = 0; i < 5; i++)
         step(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'b0);
      idle(3);

      // 4-pixel line, interpolated vs replicated odd chroma
      pixC(8'd10, 8'd100, {8'd10, 8'd100, 8'd200}, {8'd10, 8'd100, 8'd200});
      pixC(8'd20, 8'd200, {8'd20, 8'd110, 8'd200}, {8'd20, 8'd100, 8'd200});
      pixC(8'd30, 8'd120, {8'd30, 8'd120, 8'd220}, {8'd30, 8'd120, 8'd220});
      pixC(8'd40, 8'd220, {8'd40, 8'd120, 8'd220}, {8'd40, 8'd120, 8'd220});
      idle(3);

      // Odd-length 3-pixel line and a single-pixel line
      pixC(8'd10, 8'd100, {8'd10, 8'd100, 8'd200}, {8'd10, 8'd100, 8'd200});
      pixC(8'd20, 8'd200, {8'd20, 8'd75,  8'd200}, {8'd20, 8'd100, 8'd200});
      pixC(8'd30, 8'd50,  {8'd30, 8'd50,  8'd200}, {8'd30, 8'd50,  8'd200});
      idle(2);
      pixC(8'd7,  8'd90,  {8'd7,  8'd90,  8'd128}, {8'd7,  8'd90,  8'd128});
      idle(2);

      // Back-to-back lines with a single-cycle DE gap
      pixC(8'd1, 8'd50, {8'd1, 8'd50, 8'd60}, {8'd1, 8'd50, 8'd60});
      pixC(8'd2, 8'd60, {8'd2, 8'd60, 8'd60}, {8'd2, 8'd50, 8'd60});
      pixC(8'd3, 8'd70, {8'd3, 8'd70, 8'd80}, {8'd3, 8'd70, 8'd80});
      pixC(8'd4, 8'd80, {8'd4, 8'd70, 8'd80}, {8'd4, 8'd70, 8'd80});
      idle(1);
      pixC(8'd5, 8'd10, {8'd5, 8'd10, 8'd20}, {8'd5, 8'd10, 8'd20});
      pixC(8'd6, 8'd20, {8'd6, 8'd20, 8'd20}, {8'd6, 8'd10, 8'd20});
      pixC(8'd7, 8'd30, {8'd7, 8'd30, 8'd40}, {8'd7, 8'd30, 8'd40});
      pixC(8'd8, 8'd40, {8'd8, 8'd30, 8'd40}, {8'd8, 8'd30, 8'd40});
      idle(2);

      // Rounding extremes of the average
      pix(8'd1, 8'd255);
      pixC(8'd2, 8'd0, {8'd2, 8'd255, 8'd0}, {8'd2, 8'd255, 8'd0});
      pix(8'd3, 8'd255);
      pix(8'd4, 8'd0);
      idle(1);
      pix(8'd1, 8'd0);
      pixC(8'd2, 8'd9, {8'd2, 8'd1, 8'd9}, {8'd2, 8'd0, 8'd9});
      pix(8'd3, 8'd1);
      pix(8'd4, 8'd9);
      idle(2);

      // Reset in the middle of a line; rest of that line is discarded
      pix(8'd1, 8'd11);
      pix(8'd2, 8'd22);
      step(1'b1, 1'b0, 1'b0, {8'd3, 8'd33}, 1'b0);
      step(1'b1, 1'b0, 1'b0, {8'd4, 8'd44}, 1'b0);
      for (int i = 0; i < 4; i++) pix(8'(i + 5), 8'(i * 17 + 3));
      idle(1);
      pixC(8'd50, 8'd100, {8'd50, 8'd100, 8'd200}, {8'd50, 8'd100, 8'd200});
      pixC(8'd60, 8'd200, {8'd60, 8'd110, 8'd200}, {8'd60, 8'd100, 8'd200});
      pixC(8'd70, 8'd120, {8'd70, 8'd120, 8'd220}, {8'd70, 8'd120, 8'd220});
      pixC(8'd80, 8'd220, {8'd80, 8'd120, 8'd220}, {8'd80, 8'd120, 8'd220});
      idle(2);

      // Random lines, sync pulses, stray iV restarts and occasional resets
      for (int ln = 0; ln < 70; ln++) begin
         len = $urandom_range(1, 3);
         for (int g = 0; g < len; g++) begin
            rn = ($urandom_range(0, 39) != 0);
            step(1'b0, ($urandom_range(0, 9) == 0), 1'($urandom), 16'($urandom), rn);
         end
         len = $urandom_range(1, 9);
         for (int i = 0; i < len; i++) begin
            e  = 1'b1;
            v  = ($urandom_range(0, 15) == 0);
            h  = 1'($urandom);
            rn = ($urandom_range(0, 59) != 0);
            step(e, v, h, 16'($urandom), rn);
         end
      end
      idle(6);

      // Every directed expectation must have been reached
      cmp("directed_drained", 24'(constP.size()), 24'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
